// File: rtl/imem_fetch_arbiter.sv
// Round-robin two-port line fetch arbiter/sequencer for the instruction memory.
// Optional one-line buffer enabled by defining IMEM_LINE_BUFFER_EN.
module imem_fetch_arbiter #(
    parameter int unsigned LATENCY = 7
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         req0,
    input  logic [31:0]  addr0,
    input  logic         req1,
    input  logic [31:0]  addr1,
    output logic         ack0,
    output logic         ack1,
    output logic [127:0] rdata,
    output logic         busy,
    output logic [31:0]  memAddress,
    input  logic [127:0] memData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  counter;
    logic [3:0]  counter_nxt;
    logic        winner;
    logic        last_grant;
    logic        pick;
    logic [27:0] pick_line;
    logic        start;
    logic        hit;
    logic        capture;
    logic        unused_low;

    assign unused_low = ^{addr0[3:0], addr1[3:0]};

    // On a tie the requester not granted last time wins.
    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = ~last_grant;
        end
    end

    assign pick_line = pick ? addr1[31:4] : addr0[31:4];
    assign start     = (state == IDLE) && (req0 || req1);
    assign capture   = (state == WAIT) && (counter == 4'd0);

`ifdef IMEM_LINE_BUFFER_EN
    logic [27:0] buf_tag;
    logic        buf_valid;

    assign hit = buf_valid && (buf_tag == pick_line);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            buf_tag   <= '0;
            buf_valid <= 1'b0;
        end else if (capture) begin
            buf_tag   <= memAddress[31:4];
            buf_valid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    if (hit) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt   = WAIT;
                        counter_nxt = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (counter == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    counter_nxt = counter - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                counter_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
        end
    end

    // memAddress only moves on a real memory fetch so a repeated
    // line does not restart settling in the memory.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            winner     <= 1'b0;
            last_grant <= 1'b1;
            memAddress <= '0;
        end else if (start) begin
            winner     <= pick;
            last_grant <= pick;
            if (!hit) begin
                memAddress <= {pick_line, 4'b0000};
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rdata <= '0;
        end else if (capture) begin
            rdata <= memData;
        end
    end

    assign busy = (state != IDLE);
    assign ack0 = (state == RESP) && !winner;
    assign ack1 = (state == RESP) && winner;

endmodule
